// File: rtl/char_box_locator_pkg.sv
// Shared definitions for the character box locator and the downstream feature-scan stage.
// Holds FSM encodings, coordinate width and the default search window.
package char_box_locator_pkg;

  localparam int COORD_W = 12;

  localparam logic [COORD_W-1:0] DEF_WIN_LEFT   = 12'd0;
  localparam logic [COORD_W-1:0] DEF_WIN_RIGHT  = 12'd639;
  localparam logic [COORD_W-1:0] DEF_WIN_TOP    = 12'd0;
  localparam logic [COORD_W-1:0] DEF_WIN_BOTTOM = 12'd479;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    CALC1  = 3'd2,
    CALC2  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  function automatic logic in_range(input logic [COORD_W-1:0] v,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/char_box_minmax.sv
// Single-axis min/max tracker: init restores the empty range (min=all ones, max=0),
// upd folds one coordinate into the running range.
module char_box_minmax
  import char_box_locator_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic               upd,
  input  logic [COORD_W-1:0] val,
  output logic [COORD_W-1:0] min_o,
  output logic [COORD_W-1:0] max_o
);

  logic [COORD_W-1:0] min_q, min_d;
  logic [COORD_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (init) begin
      min_d = '1;
      max_d = '0;
    end else if (upd) begin
      if (val < min_q) min_d = val;
      if (val > max_q) max_d = val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/char_box_locator.sv
// Measures the foreground bounding box inside a search window once per frame and publishes
// frame-stable geometry. CHAR_BOX_HOLD_LAST_EN: invalid frames keep the last good geometry.
module char_box_locator
  import char_box_locator_pkg::*;
#(
  parameter logic [COORD_W-1:0] WIN_LEFT   = DEF_WIN_LEFT,
  parameter logic [COORD_W-1:0] WIN_RIGHT  = DEF_WIN_RIGHT,
  parameter logic [COORD_W-1:0] WIN_TOP    = DEF_WIN_TOP,
  parameter logic [COORD_W-1:0] WIN_BOTTOM = DEF_WIN_BOTTOM,
  parameter logic [COORD_W-1:0] MIN_W      = 12'd8,
  parameter logic [COORD_W-1:0] MIN_H      = 12'd16,
  parameter logic [7:0]         ROW_K1     = 8'd85,
  parameter logic [7:0]         ROW_K2     = 8'd171
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_th,
  output logic [COORD_W-1:0] char_up,
  output logic [COORD_W-1:0] char_down,
  output logic [COORD_W-1:0] char_left,
  output logic [COORD_W-1:0] char_right,
  output logic [COORD_W-1:0] row_scanf_line1,
  output logic [COORD_W-1:0] row_scanf_line2,
  output logic               box_valid,
  output logic               frame_done
);

  state_t state_q, state_d;
  logic   vs_q;
  logic   vs_rise, vs_fall, in_win;
  logic   trk_init, trk_upd;

  logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
  logic               valid_q, valid_d;
  logic [19:0]        prod1, prod2;
  logic [COORD_W-1:0] line1, line2;

  logic [COORD_W-1:0] up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic [COORD_W-1:0] l1_q, l1_d, l2_q, l2_d;
  logic               box_valid_q, box_valid_d, frame_done_q, frame_done_d;
  logic               unused_bits;

  char_box_minmax u_track_x (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (trk_init),
    .upd   (trk_upd),
    .val   (i_x),
    .min_o (min_x),
    .max_o (max_x)
  );

  char_box_minmax u_track_y (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (trk_init),
    .upd   (trk_upd),
    .val   (i_y),
    .min_o (min_y),
    .max_o (max_y)
  );

  assign vs_rise = i_vs & ~vs_q;
  assign vs_fall = ~i_vs & vs_q;
  assign in_win  = in_range(i_x, WIN_LEFT, WIN_RIGHT) & in_range(i_y, WIN_TOP, WIN_BOTTOM);

  assign prod1 = {8'd0, h_q} * {12'd0, ROW_K1};
  assign prod2 = {8'd0, h_q} * {12'd0, ROW_K2};
  assign line1 = min_y + prod1[19:8];
  assign line2 = min_y + prod2[19:8];

  assign unused_bits = ^{i_hs, prod1[7:0], prod2[7:0]};

  // Outputs are registered on the CALC2->UPDATE edge so they and frame_done are visible
  // during the UPDATE cycle, three cycles after the vs_fall cycle.
  always_comb begin
    state_d      = state_q;
    trk_init     = 1'b0;
    trk_upd      = 1'b0;
    w_d          = w_q;
    h_d          = h_q;
    valid_d      = valid_q;
    up_d         = up_q;
    down_d       = down_q;
    left_d       = left_q;
    right_d      = right_q;
    l1_d         = l1_q;
    l2_d         = l2_q;
    box_valid_d  = box_valid_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          trk_init = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (vs_fall) begin
          state_d = CALC1;
        end else if (i_vs && i_de && i_th && in_win) begin
          trk_upd = 1'b1;
        end
      end
      CALC1: begin
        w_d     = max_x - min_x;
        h_d     = max_y - min_y;
        valid_d = (min_x <= max_x) && (min_y <= max_y) &&
                  ((max_x - min_x) >= MIN_W) && ((max_y - min_y) >= MIN_H);
        state_d = CALC2;
      end
      CALC2: begin
        frame_done_d = 1'b1;
        box_valid_d  = valid_q;
        if (valid_q) begin
          up_d    = min_y;
          down_d  = max_y;
          left_d  = min_x;
          right_d = max_x;
          l1_d    = line1;
          l2_d    = line2;
        end else begin
`ifdef CHAR_BOX_HOLD_LAST_EN
          box_valid_d = 1'b0;
`else
          up_d    = '0;
          down_d  = '0;
          left_d  = '0;
          right_d = '0;
          l1_d    = '0;
          l2_d    = '0;
`endif
        end
        state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vs_q         <= 1'b0;
      w_q          <= '0;
      h_q          <= '0;
      valid_q      <= 1'b0;
      up_q         <= '0;
      down_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      l1_q         <= '0;
      l2_q         <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= i_vs;
      w_q          <= w_d;
      h_q          <= h_d;
      valid_q      <= valid_d;
      up_q         <= up_d;
      down_q       <= down_d;
      left_q       <= left_d;
      right_q      <= right_d;
      l1_q         <= l1_d;
      l2_q         <= l2_d;
      box_valid_q  <= box_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign char_up         = up_q;
  assign char_down       = down_q;
  assign char_left       = left_q;
  assign char_right      = right_q;
  assign row_scanf_line1 = l1_q;
  assign row_scanf_line2 = l2_q;
  assign box_valid       = box_valid_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_char_box_locator.sv
// Scoreboard bench for char_box_locator: a pixel-level model pushes expected frame results,
// which are popped and compared when frame_done pulses.
module tb_char_box_locator;

  localparam int WL = 100;
  localparam int WR = 639;
  localparam int WT = 0;
  localparam int WB = 479;

  logic        clk = 1'b0;
  logic        rst_n, i_hs, i_vs, i_de, i_th;
  logic [11:0] i_x, i_y;
  logic [11:0] char_up, char_down, char_left, char_right, row_scanf_line1, row_scanf_line2;
  logic        box_valid, frame_done;

  always #5 clk = ~clk;

  char_box_locator #(.WIN_LEFT(12'd100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_hs            (i_hs),
    .i_vs            (i_vs),
    .i_de            (i_de),
    .i_x             (i_x),
    .i_y             (i_y),
    .i_th            (i_th),
    .char_up         (char_up),
    .char_down       (char_down),
    .char_left       (char_left),
    .char_right      (char_right),
    .row_scanf_line1 (row_scanf_line1),
    .row_scanf_line2 (row_scanf_line2),
    .box_valid       (box_valid),
    .frame_done      (frame_done)
  );

  typedef struct packed {
    logic [11:0] up, down, left, right, l1, l2;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mn_x, mx_x, mn_y, mx_y;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_clear();
    mn_x = 4095; mx_x = 0; mn_y = 4095; mx_y = 0;
  endtask

  task automatic drive_pixel(input int x, input int y, input logic th);
    @(negedge clk);
    i_de = 1'b1; i_x = x[11:0]; i_y = y[11:0]; i_th = th;
    if (th && x >= WL && x <= WR && y >= WT && y <= WB) begin
      if (x < mn_x) mn_x = x;
      if (x > mx_x) mx_x = x;
      if (y < mn_y) mn_y = y;
      if (y > mx_y) mx_y = y;
    end
  endtask

  task automatic drive_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        drive_pixel(x, y, 1'b1);
  endtask

  task automatic start_frame();
    @(negedge clk);
    i_vs = 1'b1; i_de = 1'b0; i_th = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic push_expected();
    exp_t e;
    int   w, h;
    bit   ok;
    ok = (mn_x <= mx_x) && (mn_y <= mx_y);
    w  = mx_x - mn_x;
    h  = mx_y - mn_y;
    ok = ok && (w >= 8) && (h >= 16);
    if (ok) begin
      e.up = 12'(mn_y); e.down = 12'(mx_y); e.left = 12'(mn_x); e.right = 12'(mx_x);
      e.l1 = 12'(mn_y + (h * 85) / 256);
      e.l2 = 12'(mn_y + (h * 171) / 256);
      e.valid = 1'b1;
    end else begin
`ifdef CHAR_BOX_HOLD_LAST_EN
      e = last_e;
`else
      e = '0;
`endif
      e.valid = 1'b0;
    end
    last_e = e;
    exp_q.push_back(e);
  endtask

  // Ends the frame (with a foreground pixel in the vs_fall cycle that must be ignored),
  // waits for frame_done and checks latency, pulse width and the published geometry.
  task automatic applyStimulus_end_frame(input string name, input bit reraise);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    i_vs = 1'b0; i_de = 1'b1; i_th = 1'b1; i_x = 12'd630; i_y = 12'd470;
    push_expected();
    seen = 1'b0; cyc = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      i_de = 1'b0; i_th = 1'b0;
      if (reraise && c == 1) i_vs = 1'b1;
      if (frame_done === 1'b1) begin seen = 1'b1; cyc = c; end
    end
    n_tests++;
    if (cyc != 3) begin
      n_fail++;
      $display("[TB] FAIL %s.latency: got %0d cycles expected 3", name, cyc);
    end
    e = exp_q.pop_front();
    n_tests += 7;
    if (char_up !== e.up) begin n_fail++; $display("[TB] FAIL %s.up: got %0d expected %0d", name, char_up, e.up); end
    if (char_down !== e.down) begin n_fail++; $display("[TB] FAIL %s.down: got %0d expected %0d", name, char_down, e.down); end
    if (char_left !== e.left) begin n_fail++; $display("[TB] FAIL %s.left: got %0d expected %0d", name, char_left, e.left); end
    if (char_right !== e.right) begin n_fail++; $display("[TB] FAIL %s.right: got %0d expected %0d", name, char_right, e.right); end
    if (row_scanf_line1 !== e.l1) begin n_fail++; $display("[TB] FAIL %s.line1: got %0d expected %0d", name, row_scanf_line1, e.l1); end
    if (row_scanf_line2 !== e.l2) begin n_fail++; $display("[TB] FAIL %s.line2: got %0d expected %0d", name, row_scanf_line2, e.l2); end
    if (box_valid !== e.valid) begin n_fail++; $display("[TB] FAIL %s.box_valid: got %0b expected %0b", name, box_valid, e.valid); end
    @(negedge clk);
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s.pulse: got frame_done=%0b expected 0 one cycle later", name, frame_done);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests += 2;
    if ({char_up, char_down, char_left, char_right, row_scanf_line1, row_scanf_line2} !== 72'd0) begin
      n_fail++;
      $display("[TB] FAIL %s.geometry: got %0d/%0d/%0d/%0d/%0d/%0d expected all 0", name,
               char_up, char_down, char_left, char_right, row_scanf_line1, row_scanf_line2);
    end
    if ({box_valid, frame_done} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL %s.flags: got valid=%0b done=%0b expected 0/0", name, box_valid, frame_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_th = 1'b0; i_x = '0; i_y = '0;
    last_e = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_solid_block();
    start_frame();
    drive_pixel(50, 100, 1'b0);
    drive_rect(300, 320, 200, 260);
    applyStimulus_end_frame("solid_block", 1'b0);
  endtask

  task automatic test_empty_frame();
    start_frame();
    drive_pixel(200, 200, 1'b0);
    drive_pixel(400, 300, 1'b0);
    applyStimulus_end_frame("empty_frame", 1'b0);
  endtask

  task automatic test_window_clip();
    start_frame();
    drive_pixel(10, 60, 1'b1);
    drive_pixel(99, 70, 1'b1);
    drive_rect(150, 170, 50, 90);
    applyStimulus_end_frame("window_clip", 1'b0);
  endtask

  task automatic test_window_edges();
    start_frame();
    drive_pixel(100, 0, 1'b1);
    drive_pixel(639, 479, 1'b1);
    drive_pixel(640, 479, 1'b1);
    drive_pixel(300, 480, 1'b1);
    applyStimulus_end_frame("window_edges", 1'b0);
  endtask

  task automatic test_single_pixel();
    start_frame();
    drive_pixel(400, 300, 1'b1);
    applyStimulus_end_frame("single_pixel", 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    start_frame();
    drive_rect(200, 230, 100, 140);
    @(negedge clk);
    rst_n = 1'b0; i_vs = 1'b0; i_de = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_e = '0;
    start_frame();
    drive_rect(250, 280, 300, 330);
    check_all_zero("mid_reset_before_update");
    applyStimulus_end_frame("after_mid_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    bit seen;
    start_frame();
    drive_rect(120, 140, 20, 60);
    applyStimulus_end_frame("b2b_first", 1'b1);
    model_clear();
    drive_rect(400, 420, 100, 140);
    @(negedge clk);
    i_vs = 1'b0; i_de = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    n_tests += 2;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL b2b_skipped.frame_done: got pulse expected none");
    end
    if (char_left !== last_e.left || char_up !== last_e.up || box_valid !== last_e.valid) begin
      n_fail++;
      $display("[TB] FAIL b2b_skipped.hold: got left=%0d up=%0d valid=%0b expected %0d/%0d/%0b",
               char_left, char_up, box_valid, last_e.left, last_e.up, last_e.valid);
    end
    start_frame();
    drive_rect(500, 530, 400, 450);
    applyStimulus_end_frame("b2b_next", 1'b0);
  endtask

  initial begin
    test_reset();
    test_solid_block();
    test_empty_frame();
    test_window_clip();
    test_window_edges();
    test_single_pixel();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
